ysyx_23060187_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060187_mem_arbiter

Overview:
- Two-master, single-slave memory arbiter for the NPC.
- Shares one memory port between the IFU (instruction fetch, read-only) and the LSU (load/store, read/write).
- One outstanding transaction at a time: accept, forward, wait for response, route response back.
- Sits between the fetch/LSU stages and the DPI-backed memory model; replaces direct memory access from the core top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; DATA_W/8 byte-mask bits.
- TIMEOUT_CYCLES, 255, response wait limit in cycles; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU request valid.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  ADDR_W  fetch address.
- ifu_resp_valid  out  1  IFU response, one-cycle pulse.
- ifu_resp_data  out  DATA_W  fetched word.
- ifu_resp_err  out  1  IFU transaction timed out.
- lsu_req_valid  in  1  LSU request valid.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_req_addr  in  ADDR_W  load/store address.
- lsu_req_wen  in  1  1 = store.
- lsu_req_wdata  in  DATA_W  store data.
- lsu_req_wmask  in  DATA_W/8  byte enables.
- lsu_resp_valid  out  1  LSU response pulse.
- lsu_resp_data  out  DATA_W  load data (0 for stores).
- lsu_resp_err  out  1  LSU transaction timed out.
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream accepts.
- mem_req_addr  out  ADDR_W  latched address.
- mem_req_wen  out  1  latched write enable (0 for IFU).
- mem_req_wdata  out  DATA_W  latched store data.
- mem_req_wmask  out  DATA_W/8  latched mask (0 for IFU).
- mem_resp_valid  in  1  downstream response valid.
- mem_resp_data  in  DATA_W  downstream read data.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; owner = none; timeout counter = 0; last_grant = IFU.
  - All valid/ready outputs = 0.
  - All data, addr, mask and err outputs = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Grant is decided combinationally from the valids.
  - The granted requester's req_ready = 1 in the same cycle; the other requester's ready = 0.
  - On handshake: latch addr/wen/wdata/wmask and owner, then go to REQ.
  - For an IFU grant, wen and wmask are latched as 0.
- REQ:
  - mem_req_valid = 1; request fields held stable.
  - On mem_req_ready: go to WAIT and clear the counter.
  - mem_resp_valid in REQ is ignored.
- WAIT:
  - mem_req_valid = 0.
  - On mem_resp_valid: register the data into the owner's resp_data, pulse the owner's resp_valid in the next cycle with err = 0, and go to IDLE.
  - The non-owner's resp outputs stay 0.
- Latency and throughput:
  - Request handshake at cycle T gives mem_req_valid at T+1.
  - mem_resp_valid at cycle R gives owner resp_valid at R+1.
  - At R+1 the arbiter is already in IDLE and may accept a new request; back-to-back throughput is one transaction per 3 cycles with zero-wait memory.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no response, pulse the owner's resp_valid with err = 1 and resp_data = 0, then go to IDLE.
  - A response arriving after its timeout is a downstream protocol violation; behaviour is undefined and need not be handled.
- Priority (default build):
  - Fixed priority, LSU over IFU: with both valid in IDLE, the LSU wins.
  - The IFU is held off with ready = 0 and must keep valid and addr stable.
- A requester may assert valid while its own transaction is in flight; it is not accepted until IDLE.
- resp_valid is a single-cycle pulse; resp_data holds its value until the next response to the same requester.
- Reset mid-transaction returns to IDLE and discards the transaction; no response is issued.

Optional Feature:
- Macro: YSYX_23060187_ARB_RR_EN.
- Defined: round-robin grant.
  - With both valid, the requester not equal to last_grant wins.
  - last_grant updates on each request handshake.
  - A single valid requester always wins.
- Undefined: fixed LSU-over-IFU priority as above; the last_grant register is not built.

Decomposition:
- Shared package (ysyx_23060187_bus_pkg): state encoding IDLE/REQ/WAIT, owner encoding NONE/IFU/LSU, default ADDR_W/DATA_W.
- Sub-module ysyx_23060187_arb_grant:
  - Combinational grant logic, taking the two valids and last_grant and producing a one-hot grant.
  - It isolates the fixed-priority vs round-robin choice.
- FSM, field latches, counter and response routing stay in the top arbiter.

Test Plan:
- IFU-only read: ifu addr 0x80000000 valid, memory ready = 1 and returns 0x00000413 one cycle after accept -> ifu_req_ready at T, mem_req_valid at T+1 with wen = 0, wmask = 0, ifu_resp_valid at R+1 with data 0x00000413, lsu_resp_valid stays 0.
- Contention, fixed priority: both valid at cycle T, LSU store addr 0x80001000, wdata 0xDEADBEEF, mask 0xF -> LSU granted first; mem sees wen = 1 and wdata 0xDEADBEEF; the IFU is granted in the IDLE cycle after the LSU response.
- Round robin with the macro defined: both valid continuously over 4 transactions -> grants alternate LSU, IFU, LSU, IFU (last_grant reset = IFU, so the LSU goes first).
- Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid held high with addr and wen stable for all 5 cycles; no resp pulse.
- Timeout with TIMEOUT_CYCLES = 4: no mem_resp_valid -> owner resp_valid with err = 1 and data 0 after 4 WAIT cycles; the next request is accepted in the following IDLE.
- Reset asserted during WAIT -> all outputs 0 immediately; no resp pulse after release; a new IFU request is serviced normally.

Source files
------------

// File: rtl/ysyx_23060187_bus_pkg.sv
// Shared encodings for the NPC memory arbiter: FSM states, transaction owners,
// grant vector bit positions and default bus widths.
package ysyx_23060187_bus_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam int GRANT_IFU = 0;
    localparam int GRANT_LSU = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_t;

endpackage

// File: rtl/ysyx_23060187_arb_grant.sv
// Combinational one-hot grant between IFU and LSU requests.
// YSYX_23060187_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module ysyx_23060187_arb_grant
    import ysyx_23060187_bus_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  logic       last_grant_lsu,
    output logic [1:0] grant
);

`ifdef YSYX_23060187_ARB_RR_EN
    // Under contention, the requester that was not served last goes first.
    always_comb begin
        grant = 2'b00;
        if (ifu_valid && lsu_valid) begin
            if (last_grant_lsu) grant[GRANT_IFU] = 1'b1;
            else                grant[GRANT_LSU] = 1'b1;
        end else if (lsu_valid) begin
            grant[GRANT_LSU] = 1'b1;
        end else if (ifu_valid) begin
            grant[GRANT_IFU] = 1'b1;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant_lsu;

    always_comb begin
        grant = 2'b00;
        if (lsu_valid)      grant[GRANT_LSU] = 1'b1;
        else if (ifu_valid) grant[GRANT_IFU] = 1'b1;
    end
`endif

endmodule

// File: rtl/ysyx_23060187_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter with one transaction in flight.
// Define YSYX_23060187_ARB_RR_EN for round-robin grant; default is fixed LSU-over-IFU priority.
module ysyx_23060187_mem_arbiter
    import ysyx_23060187_bus_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_resp_data,
    output logic                  ifu_resp_err,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_resp_data,
    output logic                  lsu_resp_err,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        grant;
    logic              last_grant_lsu;
    logic              ifu_hs;
    logic              lsu_hs;
    logic              timeout_hit;
    logic              resp_done;
    logic [DATA_W-1:0] resp_word;

    ysyx_23060187_arb_grant u_grant (
        .ifu_valid      (ifu_req_valid),
        .lsu_valid      (lsu_req_valid),
        .last_grant_lsu (last_grant_lsu),
        .grant          (grant)
    );

`ifdef YSYX_23060187_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_grant_lsu <= 1'b0;
        else if (lsu_hs) last_grant_lsu <= 1'b1;
        else if (ifu_hs) last_grant_lsu <= 1'b0;
    end
`else
    assign last_grant_lsu = 1'b0;
`endif

    // The counter holds WAIT cycles already spent, so the hit lands on the last allowed one.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign timeout_hit = (state == ST_WAIT) && !mem_resp_valid &&
                                 (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign resp_done = (state == ST_WAIT) && (mem_resp_valid || timeout_hit);
    assign resp_word = (mem_resp_valid && !mem_req_wen) ? mem_resp_data : '0;
    assign ifu_hs    = ifu_req_ready && ifu_req_valid;
    assign lsu_hs    = lsu_req_ready && lsu_req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ifu_req_ready = grant[GRANT_IFU] && !rst;
                lsu_req_ready = grant[GRANT_LSU] && !rst;
                if ((grant != 2'b00) && !rst) state_next = ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (resp_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latches, wait counter and response routing back to the owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner          <= OWN_NONE;
            cnt            <= '0;
            mem_req_addr   <= '0;
            mem_req_wen    <= 1'b0;
            mem_req_wdata  <= '0;
            mem_req_wmask  <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_data  <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;

            if (lsu_hs) begin
                owner         <= OWN_LSU;
                mem_req_addr  <= lsu_req_addr;
                mem_req_wen   <= lsu_req_wen;
                mem_req_wdata <= lsu_req_wdata;
                mem_req_wmask <= lsu_req_wmask;
            end else if (ifu_hs) begin
                owner         <= OWN_IFU;
                mem_req_addr  <= ifu_req_addr;
                mem_req_wen   <= 1'b0;
                mem_req_wdata <= '0;
                mem_req_wmask <= '0;
            end

            if (state == ST_REQ && mem_req_ready) begin
                cnt <= '0;
            end else if (state == ST_WAIT && !resp_done) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (resp_done) begin
                owner <= OWN_NONE;
                if (owner == OWN_IFU) begin
                    ifu_resp_valid <= 1'b1;
                    ifu_resp_data  <= resp_word;
                    ifu_resp_err   <= timeout_hit;
                end else if (owner == OWN_LSU) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_resp_data  <= resp_word;
                    lsu_resp_err   <= timeout_hit;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060187_mem_arbiter.sv
// Self-checking bench for ysyx_23060187_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model (honours YSYX_23060187_ARB_RR_EN).
module tb_ysyx_23060187_mem_arbiter;

    localparam int TO = 4;

`ifdef YSYX_23060187_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_req_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
    logic [3:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [3:0]  mem_req_wmask;
    logic [134:0] out_fields;

    int errors = 0;
    int checks = 0;
    bit model_last_lsu = 1'b0;

    always #5 clk = ~clk;

    assign out_fields = {ifu_resp_data, ifu_resp_err, lsu_resp_data, lsu_resp_err,
                         mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask};

    ysyx_23060187_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    // Grant rule: a lone requester wins; under contention LSU wins unless round-robin says otherwise.
    function automatic bit lsu_should_win(bit iv, bit lv);
        if (!lv) return 1'b0;
        if (!iv) return 1'b1;
        return RR ? !model_last_lsu : 1'b1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ifu_req_valid = 1'b0; ifu_req_addr = '0;
        lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
        lsu_req_wdata = '0;   lsu_req_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {ifu_req_ready, lsu_req_ready});
        end
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_valid: got %b expected 000", {ifu_resp_valid, lsu_resp_valid, mem_req_valid});
        end
        checks++;
        if (out_fields !== '0) begin
            errors++; $display("[TB] FAIL reset_fields: got %h expected 0", out_fields);
        end
        drive_idle();
        next_cycle();
        rst = 1'b0;
        model_last_lsu = 1'b0;
        next_cycle();
    endtask

    task automatic test_ifu_read();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b100) begin
            errors++; $display("[TB] FAIL ifu_accept: got %b expected 100", {ifu_req_ready, lsu_req_ready, mem_req_valid});
        end
        next_cycle();
        ifu_req_valid = 1'b0; model_last_lsu = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin
            errors++; $display("[TB] FAIL ifu_mem_req: got v=%b a=%h w=%b m=%h", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
        end
        next_cycle();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0413;
        next_cycle();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        checks++;
        if ({ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid} !== {1'b1, 32'h0000_0413, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL ifu_resp: got v=%b d=%h e=%b lsu_v=%b expected 1 00000413 0 0", ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ifu_resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL ifu_resp_pulse: got %b expected 0", ifu_resp_valid);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1'b1;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
        @(negedge clk);
        checks++;
        if ({ifu_req_ready, lsu_req_ready} !== (lsu_should_win(1'b1, 1'b1) ? 2'b01 : 2'b10)) begin
            errors++; $display("[TB] FAIL contention_grant: got %b", {ifu_req_ready, lsu_req_ready});
        end
        next_cycle();
        lsu_req_valid = 1'b0; model_last_lsu = 1'b1; mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, ifu_req_ready} !==
            {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
            errors++; $display("[TB] FAIL store_mem_req: got a=%h w=%b d=%h m=%h ifu_rdy=%b", mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, ifu_req_ready);
        end
        next_cycle();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
        next_cycle();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        checks++;
        if ({lsu_resp_valid, lsu_resp_data, lsu_resp_err, ifu_resp_valid, ifu_req_ready} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("[TB] FAIL store_resp: got v=%b d=%h e=%b ifu_v=%b ifu_rdy=%b", lsu_resp_valid, lsu_resp_data, lsu_resp_err, ifu_resp_valid, ifu_req_ready);
        end
        next_cycle();
        ifu_req_valid = 1'b0; model_last_lsu = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask} !== {1'b1, 32'h8000_0004, 1'b0, 4'h0}) begin
            errors++; $display("[TB] FAIL deferred_ifu_req: got v=%b a=%h w=%b m=%h", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask);
        end
        next_cycle();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0010_0093;
        next_cycle();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        checks++;
        if ({ifu_resp_valid, ifu_resp_data} !== {1'b1, 32'h0010_0093}) begin
            errors++; $display("[TB] FAIL deferred_ifu_resp: got v=%b d=%h expected 1 00100093", ifu_resp_valid, ifu_resp_data);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
        @(negedge clk);
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_accept: got %b expected 1", ifu_req_ready);
        end
        next_cycle();
        ifu_req_valid = 1'b0; model_last_lsu = 1'b0; mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({mem_req_valid, mem_req_addr, mem_req_wen, ifu_resp_valid, lsu_resp_valid} !== {1'b1, 32'h8000_0040, 1'b0, 2'b00}) begin
                errors++; $display("[TB] FAIL bp_hold[%0d]: got v=%b a=%h w=%b resp=%b%b", k, mem_req_valid, mem_req_addr, mem_req_wen, ifu_resp_valid, lsu_resp_valid);
            end
            next_cycle();
        end
        mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0297;
        next_cycle();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        checks++;
        if ({ifu_resp_valid, ifu_resp_data} !== {1'b1, 32'h0000_0297}) begin
            errors++; $display("[TB] FAIL bp_resp: got v=%b d=%h expected 1 00000297", ifu_resp_valid, ifu_resp_data);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1'b0;
        lsu_req_wdata = '0; lsu_req_wmask = 4'hF;
        @(negedge clk);
        checks++;
        if (lsu_req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL to_accept: got %b expected 1", lsu_req_ready);
        end
        next_cycle();
        lsu_req_valid = 1'b0; model_last_lsu = 1'b1; mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            checks++;
            if ({lsu_resp_valid, mem_req_valid} !== 2'b00) begin
                errors++; $display("[TB] FAIL to_wait[%0d]: got resp=%b req=%b expected 00", k, lsu_resp_valid, mem_req_valid);
            end
            next_cycle();
        end
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0080;
        @(negedge clk);
        checks++;
        if ({lsu_resp_valid, lsu_resp_err, lsu_resp_data} !== {1'b1, 1'b1, 32'h0}) begin
            errors++; $display("[TB] FAIL to_resp: got v=%b e=%b d=%h expected 1 1 0", lsu_resp_valid, lsu_resp_err, lsu_resp_data);
        end
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL to_next_accept: got %b expected 1", ifu_req_ready);
        end
        next_cycle();
        ifu_req_valid = 1'b0; model_last_lsu = 1'b0; mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
        next_cycle();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        checks++;
        if ({ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid} !== {1'b1, 32'hCAFE_F00D, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL to_after_resp: got v=%b d=%h e=%b lsu_v=%b", ifu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_valid);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_00C0;
        next_cycle();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 5'b0) begin
            errors++; $display("[TB] FAIL midrst_valid: got %b expected 00000", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid});
        end
        checks++;
        if (out_fields !== '0) begin
            errors++; $display("[TB] FAIL midrst_fields: got %h expected 0", out_fields);
        end
        next_cycle();
        rst = 1'b0; model_last_lsu = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0BAD_0BAD;
        next_cycle();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000) begin
                errors++; $display("[TB] FAIL midrst_quiet[%0d]: got %b expected 000", k, {ifu_resp_valid, lsu_resp_valid, mem_req_valid});
            end
            next_cycle();
        end
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0100;
        next_cycle();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0100}) begin
            errors++; $display("[TB] FAIL midrst_new_req: got v=%b a=%h", mem_req_valid, mem_req_addr);
        end
        next_cycle();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0517;
        next_cycle();
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        checks++;
        if ({ifu_resp_valid, ifu_resp_data, ifu_resp_err} !== {1'b1, 32'h0000_0517, 1'b0}) begin
            errors++; $display("[TB] FAIL midrst_new_resp: got v=%b d=%h e=%b", ifu_resp_valid, ifu_resp_data, ifu_resp_err);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bit prev_lsu = 1'b0;
        bit exp_lsu;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; model_last_lsu = 1'b0;
        next_cycle();
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_wmask = 4'hF;
        for (int i = 0; i <= 4; i++) begin
            ifu_req_addr = 32'h8000_0200 + 32'(i * 4);
            lsu_req_addr = 32'h8000_2000 + 32'(i * 4);
            if (i == 4) begin
                ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({ifu_resp_valid, lsu_resp_valid, (prev_lsu ? lsu_resp_data : ifu_resp_data)} !==
                    {~prev_lsu, prev_lsu, 32'hA0 + 32'(i - 1)}) begin
                    errors++; $display("[TB] FAIL b2b_resp[%0d]: got %b%b ifu_d=%h lsu_d=%h", i - 1, ifu_resp_valid, lsu_resp_valid, ifu_resp_data, lsu_resp_data);
                end
            end
            if (i == 4) begin
                next_cycle();
                break;
            end
            exp_lsu = lsu_should_win(1'b1, 1'b1);
            checks++;
            if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
                errors++; $display("[TB] FAIL b2b_grant[%0d]: got %b expected %b", i, {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu});
            end
            next_cycle();
            model_last_lsu = exp_lsu; prev_lsu = exp_lsu; mem_req_ready = 1'b1;
            next_cycle();
            mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hA0 + 32'(i);
            next_cycle();
            mem_resp_valid = 1'b0; mem_resp_data = '0;
        end
    endtask

    task automatic test_random();
        localparam int NITER = 40;
        bit ifu_pend = 1'b0, lsu_pend = 1'b0;
        bit have_prev = 1'b0, prev_lsu = 1'b0, prev_err = 1'b0;
        bit exp_lsu, timed_out;
        logic [31:0] i_addr = '0, l_addr = '0, l_wdata = '0, prev_data = '0, rd, exp_addr;
        logic l_wen = 1'b0;
        logic [3:0] l_mask = '0;
        int d1, d2;
        for (int it = 0; it < 3 * NITER; it++) begin
            if (it < NITER && !ifu_pend && !lsu_pend) begin
                ifu_pend = 1'($urandom_range(0, 1));
                lsu_pend = 1'($urandom_range(0, 1));
                if (!ifu_pend && !lsu_pend) ifu_pend = 1'b1;
                if (ifu_pend) i_addr = $urandom;
                if (lsu_pend) begin
                    l_addr = $urandom; l_wdata = $urandom;
                    l_wen = 1'($urandom_range(0, 1)); l_mask = 4'($urandom_range(0, 15));
                end
            end
            ifu_req_valid = ifu_pend; ifu_req_addr = i_addr;
            lsu_req_valid = lsu_pend; lsu_req_addr = l_addr; lsu_req_wen = l_wen;
            lsu_req_wdata = l_wdata; lsu_req_wmask = l_mask;
            @(negedge clk);
            if (have_prev) begin
                checks++;
                if ({ifu_resp_valid, lsu_resp_valid, (prev_lsu ? lsu_resp_data : ifu_resp_data),
                     (prev_lsu ? lsu_resp_err : ifu_resp_err)} !== {~prev_lsu, prev_lsu, prev_data, prev_err}) begin
                    errors++; $display("[TB] FAIL rnd_resp[%0d]: got v=%b%b ifu=%h/%b lsu=%h/%b expected owner_lsu=%b d=%h e=%b", it, ifu_resp_valid, lsu_resp_valid, ifu_resp_data, ifu_resp_err, lsu_resp_data, lsu_resp_err, prev_lsu, prev_data, prev_err);
                end
            end
            if (!ifu_pend && !lsu_pend) begin
                next_cycle();
                break;
            end
            exp_lsu = lsu_should_win(ifu_pend, lsu_pend);
            checks++;
            if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
                errors++; $display("[TB] FAIL rnd_grant[%0d]: got %b expected %b", it, {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu});
            end
            next_cycle();
            model_last_lsu = exp_lsu;
            if (exp_lsu) begin lsu_pend = 1'b0; lsu_req_valid = 1'b0; end
            else         begin ifu_pend = 1'b0; ifu_req_valid = 1'b0; end
            exp_addr = exp_lsu ? l_addr : i_addr;
            d1 = $urandom_range(0, 2);
            for (int k = 0; k <= d1; k++) begin
                mem_req_ready = (k == d1);
                @(negedge clk);
                checks++;
                if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr ||
                    mem_req_wen !== (exp_lsu && l_wen) || mem_req_wmask !== (exp_lsu ? l_mask : 4'h0) ||
                    (exp_lsu && l_wen && mem_req_wdata !== l_wdata) ||
                    ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
                    errors++; $display("[TB] FAIL rnd_req[%0d]: got v=%b a=%h w=%b d=%h m=%h rdy=%b%b expected a=%h", it, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, ifu_req_ready, lsu_req_ready, exp_addr);
                end
                next_cycle();
            end
            mem_req_ready = 1'b0;
            timed_out = ($urandom_range(0, 5) == 0);
            rd = '0;
            if (timed_out) begin
                for (int k = 0; k < TO; k++) begin
                    @(negedge clk);
                    checks++;
                    if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000) begin
                        errors++; $display("[TB] FAIL rnd_wait[%0d]: got %b expected 000", it, {ifu_resp_valid, lsu_resp_valid, mem_req_valid});
                    end
                    next_cycle();
                end
            end else begin
                d2 = $urandom_range(0, TO - 2);
                repeat (d2) next_cycle();
                rd = $urandom;
                mem_resp_valid = 1'b1; mem_resp_data = rd;
                next_cycle();
                mem_resp_valid = 1'b0; mem_resp_data = '0;
            end
            have_prev = 1'b1; prev_lsu = exp_lsu; prev_err = timed_out;
            prev_data = (timed_out || (exp_lsu && l_wen)) ? 32'h0 : rd;
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        next_cycle();
        test_reset();
        test_ifu_read();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
